// File: rtl/spi_pkg.sv
// Shared types and constants for the oversampled SPI slave.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // SPI modes encoded as {CPOL, CPHA}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Depth of the metastability synchroniser on every async pin
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronises one asynchronous pin into clk and flags its edges.
// The previous-value register sits after the synchroniser, so rise/fall
// are valid two clocks after the pin moves and are acted on at the third.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Next values of the synchroniser chain and edge-history register
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Registers reset to the pin's idle level so reset release is edge-free
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_os.sv
// Oversampled SPI slave: all four modes, configurable width and bit order,
// back-to-back words per frame, TX holding register with ready/write handshake.
module spi_slave_os
  import spi_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic             SS,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] TX_DAT,
  input  logic             TX_WE,
  output logic             TX_READY,
  output logic [WIDTH-1:0] RX_DAT,
  output logic             RX_VALID,
  output logic             BUSY,
  output logic             TX_UNDERRUN,
  output logic             FRAME_ERR
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk   (clk),
    .clr   (clr),
    .pin   (SCLK),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_ss_sync (
    .clk   (clk),
    .clr   (clr),
    .pin   (SS),
    .level (ss_lvl),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  // MOSI needs only a level, aligned in latency with the SCLK edge flags
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  // Next value of the MOSI synchroniser chain
  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
  end

  // MOSI synchroniser
  always_ff @(posedge clk or posedge clr) begin
    if (clr) mosi_sync_q <= '0;
    else     mosi_sync_q <= mosi_sync_d;
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Leading edge leaves CPOL, trailing edge returns to it
  logic sclk_edge, lead_ev, trail_ev, sample_ev, shift_ev;
  assign sclk_edge = sclk_rise | sclk_fall;
  assign lead_ev   = sclk_edge & (sclk_lvl != CPOL);
  assign trail_ev  = sclk_edge & (sclk_lvl == CPOL);
  // A sample coinciding with SS rising sees ss_lvl high and is dropped
  assign sample_ev = (CPHA ? trail_ev : lead_ev) & ~ss_lvl;
  assign shift_ev  = CPHA ? lead_ev : trail_ev;

  state_e           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] rx_dat_q, rx_dat_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic             frame_err_q, frame_err_d;
  logic             do_load;

  // Frame control, RX assembly, TX shifting and holding-register handshake
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_dat_d    = rx_dat_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_err_d = 1'b0;
    do_load     = 1'b0;

    if (TX_WE && !hold_full_q) begin
      hold_d      = TX_DAT;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          do_load   = !CPHA;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          frame_err_d = (bit_cnt_q != '0);
        end else begin
          if (sample_ev) begin
            rx_shift_d = MSB_FIRST ? {rx_shift_q[WIDTH-2:0], mosi_s}
                                   : {mosi_s, rx_shift_q[WIDTH-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              rx_dat_d   = rx_shift_d;
              rx_valid_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (shift_ev) begin
            if (bit_cnt_q == '0) begin
              do_load = 1'b1;
            end else begin
              tx_shift_d = MSB_FIRST ? {tx_shift_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, tx_shift_q[WIDTH-1:1]};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Word load: holding register, then same-cycle bypass, else underrun
    if (do_load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else if (TX_WE) begin
        tx_shift_d  = TX_DAT;
        hold_d      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end
  end

  // State registers; reset also empties the holding register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_dat_q    <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_dat_q    <= rx_dat_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign BUSY        = (state_q == ACTIVE);
  assign MISO_OE     = BUSY;
  assign MISO        = BUSY & (MSB_FIRST ? tx_shift_q[WIDTH-1] : tx_shift_q[0]);
  assign TX_READY    = ~hold_full_q;
  assign RX_DAT      = rx_dat_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_UNDERRUN = underrun_q;
  assign FRAME_ERR   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_os.sv
// Directed bench for spi_slave_os: four instances cover modes 0, 1, 3 and
// an 8-bit LSB-first mode-0 variant, driven by a shared bit-banged master.
module tb_spi_slave_os;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [3:0]  sclk = 4'b0100;
  logic [3:0]  ss   = 4'b1111;
  logic        mosi = 1'b0;
  logic [3:0]  tx_we = 4'b0;
  logic [11:0] tx_dat0 = '0, tx_dat1 = '0, tx_dat2 = '0;
  logic [7:0]  tx_dat3 = '0;

  wire  [3:0]  miso, miso_oe, tx_ready, rx_valid, busy, und, ferr;
  wire  [11:0] rx_dat0, rx_dat1, rx_dat2;
  wire  [7:0]  rx_dat3;

  always #5 clk = ~clk;

  spi_slave_os #(.WIDTH(12), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1)) u_m0 (
    .clk(clk), .clr(clr), .SCLK(sclk[0]), .MOSI(mosi), .SS(ss[0]),
    .MISO(miso[0]), .MISO_OE(miso_oe[0]), .TX_DAT(tx_dat0), .TX_WE(tx_we[0]),
    .TX_READY(tx_ready[0]), .RX_DAT(rx_dat0), .RX_VALID(rx_valid[0]), .BUSY(busy[0]),
    .TX_UNDERRUN(und[0]), .FRAME_ERR(ferr[0]));

  spi_slave_os #(.WIDTH(12), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m1 (
    .clk(clk), .clr(clr), .SCLK(sclk[1]), .MOSI(mosi), .SS(ss[1]),
    .MISO(miso[1]), .MISO_OE(miso_oe[1]), .TX_DAT(tx_dat1), .TX_WE(tx_we[1]),
    .TX_READY(tx_ready[1]), .RX_DAT(rx_dat1), .RX_VALID(rx_valid[1]), .BUSY(busy[1]),
    .TX_UNDERRUN(und[1]), .FRAME_ERR(ferr[1]));

  spi_slave_os #(.WIDTH(12), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1)) u_m3 (
    .clk(clk), .clr(clr), .SCLK(sclk[2]), .MOSI(mosi), .SS(ss[2]),
    .MISO(miso[2]), .MISO_OE(miso_oe[2]), .TX_DAT(tx_dat2), .TX_WE(tx_we[2]),
    .TX_READY(tx_ready[2]), .RX_DAT(rx_dat2), .RX_VALID(rx_valid[2]), .BUSY(busy[2]),
    .TX_UNDERRUN(und[2]), .FRAME_ERR(ferr[2]));

  spi_slave_os #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .SCLK(sclk[3]), .MOSI(mosi), .SS(ss[3]),
    .MISO(miso[3]), .MISO_OE(miso_oe[3]), .TX_DAT(tx_dat3), .TX_WE(tx_we[3]),
    .TX_READY(tx_ready[3]), .RX_DAT(rx_dat3), .RX_VALID(rx_valid[3]), .BUSY(busy[3]),
    .TX_UNDERRUN(und[3]), .FRAME_ERR(ferr[3]));

  int n_assert = 0;
  int n_fail   = 0;
  int rxv_cnt [4] = '{0, 0, 0, 0};
  int und_cnt [4] = '{0, 0, 0, 0};
  int ferr_cnt[4] = '{0, 0, 0, 0};

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) rxv_cnt[i]++;
      if (und[i])      und_cnt[i]++;
      if (ferr[i])     ferr_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (5) @(negedge clk);
  endtask

  task automatic tx_write(input int idx, input logic [11:0] v);
    @(negedge clk);
    case (idx)
      0: tx_dat0 = v;
      1: tx_dat1 = v;
      2: tx_dat2 = v;
      default: tx_dat3 = v[7:0];
    endcase
    tx_we[idx] = 1'b1;
    @(negedge clk);
    tx_we[idx] = 1'b0;
  endtask

  // One word (or the first nbits of it) from the master's side
  task automatic word(input int idx, input bit cpol, input bit cpha, input int width,
                      input bit msb, input logic [31:0] tx, input int nbits,
                      output logic [31:0] rx);
    rx = '0;
    for (int b = 0; b < nbits; b++) begin
      int pos;
      pos = msb ? (width - 1 - b) : b;
      if (!cpha) begin
        mosi = tx[pos];
        half();
        sclk[idx] = ~cpol;
        rx[pos] = miso[idx];
        half();
        sclk[idx] = cpol;
      end else begin
        sclk[idx] = ~cpol;
        mosi = tx[pos];
        half();
        sclk[idx] = cpol;
        rx[pos] = miso[idx];
        half();
      end
    end
  endtask

  task automatic frame_start(input int idx);
    ss[idx] = 1'b0;
    half();
  endtask

  task automatic frame_end(input int idx);
    half();
    ss[idx] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  logic [31:0] r_a, r_b;
  int v0, u0, f0;

  initial begin
    repeat (5) @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);

    // Reset state
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_oe", 32'(miso_oe), 32'h0);
    check("rst_ready", 32'(tx_ready), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rxdat0", 32'(rx_dat0), 32'h0);
    check("rst_pulses", 32'({rx_valid, und, ferr}), 32'h0);

    // Mode 0 single word
    tx_write(0, 12'h3F1);
    @(negedge clk);
    check("m0_ready_low", 32'(tx_ready[0]), 32'h0);
    v0 = rxv_cnt[0];
    ss[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("m0_ready_at_start", 32'(tx_ready[0]), 32'h1);
    check("m0_busy", 32'(busy[0]), 32'h1);
    check("m0_oe", 32'(miso_oe[0]), 32'h1);
    word(0, 1'b0, 1'b0, 12, 1'b1, 32'hA5C, 12, r_a);
    frame_end(0);
    check("m0_rx", 32'(rx_dat0), 32'hA5C);
    check("m0_rxv_count", 32'(rxv_cnt[0] - v0), 32'h1);
    check("m0_miso_word", r_a, 32'h3F1);
    check("m0_busy_end", 32'(busy[0]), 32'h0);

    // Mode 3 two back-to-back words, second TX word written on TX_READY
    tx_write(2, 12'h456);
    @(negedge clk);
    v0 = rxv_cnt[2];
    u0 = und_cnt[2];
    fork
      begin
        frame_start(2);
        word(2, 1'b1, 1'b1, 12, 1'b1, 32'h123, 12, r_a);
        check("m3_rx_word1", 32'(rx_dat2), 32'h123);
        word(2, 1'b1, 1'b1, 12, 1'b1, 32'hFED, 12, r_b);
        frame_end(2);
      end
      begin : feeder
        int k;
        k = 0;
        while (!tx_ready[2] && k < 500) begin
          @(negedge clk);
          k++;
        end
        check("m3_ready_wait", 32'(k < 500), 32'h1);
        tx_write(2, 12'h789);
      end
    join
    check("m3_rx_word2", 32'(rx_dat2), 32'hFED);
    check("m3_rxv_count", 32'(rxv_cnt[2] - v0), 32'h2);
    check("m3_miso_word1", r_a, 32'h456);
    check("m3_miso_word2", r_b, 32'h789);
    check("m3_underrun", 32'(und_cnt[2] - u0), 32'h0);

    // Mode 1 with nothing written: underrun on the first leading edge
    u0 = und_cnt[1];
    frame_start(1);
    check("m1_no_und_before_edge", 32'(und_cnt[1] - u0), 32'h0);
    word(1, 1'b0, 1'b1, 12, 1'b1, 32'h5A3, 12, r_a);
    frame_end(1);
    check("m1_und_count", 32'(und_cnt[1] - u0), 32'h1);
    check("m1_miso_word", r_a, 32'h000);
    check("m1_rx", 32'(rx_dat1), 32'h5A3);

    // Mode 0 frame aborted after 5 bits
    v0 = rxv_cnt[0];
    f0 = ferr_cnt[0];
    frame_start(0);
    word(0, 1'b0, 1'b0, 12, 1'b1, 32'h3C3, 5, r_a);
    frame_end(0);
    check("ferr_count", 32'(ferr_cnt[0] - f0), 32'h1);
    check("ferr_no_rxv", 32'(rxv_cnt[0] - v0), 32'h0);
    check("ferr_rx_held", 32'(rx_dat0), 32'hA5C);
    check("ferr_oe", 32'(miso_oe[0]), 32'h0);

    // 8-bit LSB-first
    tx_write(3, 12'h080);
    frame_start(3);
    word(3, 1'b0, 1'b0, 8, 1'b0, 32'h01, 8, r_a);
    frame_end(3);
    check("lsb_rx", 32'(rx_dat3), 32'h01);
    check("lsb_miso_word", r_a, 32'h80);

    // clr mid-frame with SS held low
    frame_start(0);
    word(0, 1'b0, 1'b0, 12, 1'b1, 32'hFFF, 6, r_a);
    tx_write(0, 12'h555);
    @(negedge clk);
    check("clr_ready_before", 32'(tx_ready[0]), 32'h0);
    clr = 1'b1;
    #1;
    check("clr_busy", 32'(busy[0]), 32'h0);
    check("clr_oe", 32'(miso_oe[0]), 32'h0);
    check("clr_miso", 32'(miso[0]), 32'h0);
    check("clr_ready", 32'(tx_ready[0]), 32'h1);
    check("clr_rxdat", 32'(rx_dat0), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    repeat (5) @(negedge clk);
    v0 = rxv_cnt[0];
    word(0, 1'b0, 1'b0, 12, 1'b1, 32'hABC, 12, r_a);
    repeat (5) @(negedge clk);
    check("clr_no_frame_busy", 32'(busy[0]), 32'h0);
    check("clr_no_frame_rxv", 32'(rxv_cnt[0] - v0), 32'h0);
    ss[0] = 1'b1;
    repeat (10) @(negedge clk);
    ss[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("clr_new_frame_busy", 32'(busy[0]), 32'h1);
    frame_end(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
